loop_filter_pi: RTL and testbench
=================================

Name: loop_filter_pi

Overview:
- Digital PI loop filter directly downstream of the glitch filter in the ADPLL.
- Consumes the cleaned UP/DN pulses and produces the registered DCO tuning code.
- Integral accumulator with fractional bits plus a one-cycle proportional kick.
- Two-mode gain scheduling (ACQUIRE/TRACK) driven by a small FSM.

Parameters:
CODE_W, 10, DCO code width in bits
FRAC_W, 4, fractional bits of the integral accumulator
CODE_INIT, 512, DCO code loaded at reset
KP_ACQ, 8, proportional kick in ACQUIRE (whole codes)
KP_TRK, 2, proportional kick in TRACK (whole codes)
KI_ACQ, 16, integral step in ACQUIRE (accumulator LSBs; 16 = 1 code)
KI_TRK, 4, integral step in TRACK (accumulator LSBs)
REV_CNT, 4, consecutive direction reversals needed to enter TRACK
RUN_LEN, 3, consecutive same-direction events that force a return to ACQUIRE
LOCK_WIN, 64, TRACK cycles without a same-direction repeat needed to assert locked

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
UP_in  input  1  filtered UP level from the glitch filter
DN_in  input  1  filtered DN level from the glitch filter
dco_code  output  CODE_W  registered DCO tuning word
mode  output  1  0 = ACQUIRE, 1 = TRACK
code_sat  output  1  integral accumulator pinned at its minimum or maximum
locked  output  1  lock indicator (optional feature)

Behaviour:
- Reset: sampled only on the rising edge of clk while reset is 0. Applies the following values:
  - acc = CODE_INIT<<FRAC_W; dco_code = CODE_INIT; mode = ACQUIRE.
  - code_sat = 0; locked = 0; all counters = 0.
  - UP_q/DN_q load the current UP_in/DN_in, so a level held high through reset produces no event.
- Reset asserted mid-operation restores all of the above at the next edge.
- Edge detection:
  - up_evt = UP_in & ~UP_q; dn_evt = DN_in & ~DN_q.
  - UP_q/DN_q update every cycle.
  - A level held high yields exactly one event.
- Simultaneous up_evt and dn_evt: cancel. No accumulator change, no P kick, no reversal/run counter change.
- Integral: acc is unsigned, CODE_W+FRAC_W bits.
  - up_evt: acc += KI.
  - dn_evt: acc -= KI.
  - Saturates at 0 and at 2^(CODE_W+FRAC_W)-1 (no wrap).
  - code_sat is registered and set when the post-update acc equals either bound.
- Proportional: P = +KP on up_evt, -KP on dn_evt, else 0.
- Output: dco_code <= clamp((acc_next >> FRAC_W) + P, 0, 2^CODE_W-1), registered every cycle.
  - An event detected at edge k is visible after edge k.
  - The kick is removed at edge k+1.
- Gains: KP/KI are selected by mode at the time of the event.
- FSM states ACQUIRE(0) and TRACK(1). Transitions are evaluated on non-cancelled events only.
- rev_cnt: increments when the event direction differs from the last event; cleared when the direction repeats.
- ACQUIRE→TRACK: when rev_cnt reaches REV_CNT. rev_cnt is then cleared.
- run_cnt: counts consecutive same-direction events; resets to 1 on a reversal.
- TRACK→ACQUIRE: when run_cnt reaches RUN_LEN. run_cnt is then cleared.
- The mode change takes effect for events from the next cycle onward.
- No events: state, acc and code hold indefinitely.

Optional Feature:
- Macro LOOP_FILTER_LOCK_DET_EN.
- Defined:
  - A lock counter runs while mode = TRACK and increments each cycle.
  - It is cleared on any same-direction repeat or on leaving TRACK.
  - locked is registered and asserts when the counter reaches LOCK_WIN; the counter saturates there.
  - locked deasserts on the cycle after a clear.
- Not defined: locked is tied to 0 and no counter logic exists.

Decomposition:
- Shared package adpll_pkg holds:
  - mode encoding constants MODE_ACQ=0 and MODE_TRK=1.
  - default CODE_W, FRAC_W and CODE_INIT.
  - the gain constants, so the DCO and other stages share them.
- One natural sub-module: pulse_edge_det (registered rising-edge detector with reset preload), instantiated for UP and DN.

Test Plan:
- Reset: reset=0 for 2 cycles with UP_in=1 held → dco_code=512, mode=0, code_sat=0, locked=0. Releasing reset with UP_in still 1 → no event, code stays 512.
- Single UP pulse in ACQUIRE → dco_code=521 (513+8) one edge after detection, 513 on the following edge. A DN pulse then gives 504, then 512.
- UP_in held 10 cycles → exactly one event, final code 513. UP and DN rising on the same cycle → code unchanged, rev_cnt unchanged.
- Alternate UP,DN,UP,DN,UP (5 events) → mode=1 after the 5th event. A further UP in TRACK moves acc by 4 (code 513→513, kick to 515). Then three consecutive DN → mode=0.
- Saturation: 512 DN events in ACQUIRE → dco_code=0, code_sat=1. A further DN keeps 0 with the P kick clamped. One UP → code 9 then 1, code_sat=0.
- With LOOP_FILTER_LOCK_DET_EN defined: enter TRACK with no same-direction repeat → locked=1 exactly 64 cycles after TRACK entry. Two consecutive UP → locked=0 next cycle. Without the macro, locked stays 0 throughout.

Source files
------------

// File: rtl/adpll_pkg.sv
// Shared ADPLL constants: mode encoding, default code geometry and loop gains.
package adpll_pkg;

  localparam logic MODE_ACQ = 1'b0;
  localparam logic MODE_TRK = 1'b1;

  typedef enum logic {
    ST_ACQ = MODE_ACQ,
    ST_TRK = MODE_TRK
  } lf_state_e;

  localparam int CODE_W_DFLT    = 10;
  localparam int FRAC_W_DFLT    = 4;
  localparam int CODE_INIT_DFLT = 512;

  localparam int KP_ACQ_DFLT = 8;
  localparam int KP_TRK_DFLT = 2;
  localparam int KI_ACQ_DFLT = 16;
  localparam int KI_TRK_DFLT = 4;

  localparam int REV_CNT_DFLT  = 4;
  localparam int RUN_LEN_DFLT  = 3;
  localparam int LOCK_WIN_DFLT = 64;

endpackage

// File: rtl/pulse_edge_det.sv
// Registered rising-edge detector. The history flop preloads the live level
// during reset, so a level already high at release produces no event.
module pulse_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic lvl_in,
  output logic evt
);

  logic lvl_q;
  logic lvl_d;

  always_comb begin
    lvl_d = lvl_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lvl_q <= lvl_in;
    end else begin
      lvl_q <= lvl_d;
    end
  end

  assign evt = reset & lvl_in & ~lvl_q;

endmodule

// File: rtl/loop_filter_pi.sv
// ADPLL PI loop filter: UP/DN events drive a saturating integral accumulator
// plus a one-cycle proportional kick, with ACQUIRE/TRACK gain scheduling.
// Optional lock detector enabled by defining LOOP_FILTER_LOCK_DET_EN.
module loop_filter_pi
  import adpll_pkg::*;
#(
  parameter int CODE_W    = CODE_W_DFLT,
  parameter int FRAC_W    = FRAC_W_DFLT,
  parameter int CODE_INIT = CODE_INIT_DFLT,
  parameter int KP_ACQ    = KP_ACQ_DFLT,
  parameter int KP_TRK    = KP_TRK_DFLT,
  parameter int KI_ACQ    = KI_ACQ_DFLT,
  parameter int KI_TRK    = KI_TRK_DFLT,
  parameter int REV_CNT   = REV_CNT_DFLT,
  parameter int RUN_LEN   = RUN_LEN_DFLT,
  parameter int LOCK_WIN  = LOCK_WIN_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              UP_in,
  input  logic              DN_in,
  output logic [CODE_W-1:0] dco_code,
  output logic              mode,
  output logic              code_sat,
  output logic              locked
);

  localparam int ACC_W = CODE_W + FRAC_W;
  localparam int RC_W  = $clog2(REV_CNT + 1);
  localparam int RL_W  = $clog2(RUN_LEN + 1);

  localparam logic [ACC_W-1:0]          ACC_MAX    = {ACC_W{1'b1}};
  localparam logic signed [ACC_W+1:0]   ACC_MAX_S  = {2'b00, {ACC_W{1'b1}}};
  localparam logic signed [CODE_W+1:0]  CODE_MAX_S = {2'b00, {CODE_W{1'b1}}};
  localparam logic [CODE_W-1:0]         CODE_RST   = CODE_INIT[CODE_W-1:0];
  localparam logic [ACC_W-1:0]          ACC_RST    = {CODE_RST, {FRAC_W{1'b0}}};
  localparam logic signed [ACC_W+1:0]   KI_ACQ_S   = KI_ACQ[ACC_W+1:0];
  localparam logic signed [ACC_W+1:0]   KI_TRK_S   = KI_TRK[ACC_W+1:0];
  localparam logic signed [CODE_W+1:0]  KP_ACQ_S   = KP_ACQ[CODE_W+1:0];
  localparam logic signed [CODE_W+1:0]  KP_TRK_S   = KP_TRK[CODE_W+1:0];
  localparam logic [RC_W-1:0]           REV_MAX    = RC_W'(REV_CNT);
  localparam logic [RL_W-1:0]           RUN_MAX    = RL_W'(RUN_LEN);

  function automatic logic [ACC_W-1:0] sat_acc(input logic signed [ACC_W+1:0] v);
    if (v < 0) return '0;
    if (v > ACC_MAX_S) return ACC_MAX;
    return v[ACC_W-1:0];
  endfunction

  function automatic logic [CODE_W-1:0] clamp_code(input logic signed [CODE_W+1:0] v);
    if (v < 0) return '0;
    if (v > CODE_MAX_S) return {CODE_W{1'b1}};
    return v[CODE_W-1:0];
  endfunction

  logic up_evt, dn_evt;

  pulse_edge_det u_up_edge (.clk(clk), .reset(reset), .lvl_in(UP_in), .evt(up_evt));
  pulse_edge_det u_dn_edge (.clk(clk), .reset(reset), .lvl_in(DN_in), .evt(dn_evt));

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              sat_q, sat_d;
  lf_state_e         mode_q, mode_d;
  logic              last_up_q, last_up_d;
  logic              has_last_q, has_last_d;
  logic [RC_W-1:0]   rev_cnt_q, rev_cnt_d;
  logic [RL_W-1:0]   run_cnt_q, run_cnt_d;

  logic evt_valid, dir_up, repeat_evt, reversal;
  logic signed [ACC_W+1:0]  ki_s, acc_sum;
  logic signed [CODE_W+1:0] p_s, code_sum;

  // Datapath: simultaneous UP/DN cancel, so only an exclusive event moves acc.
  always_comb begin
    evt_valid = up_evt ^ dn_evt;
    dir_up    = up_evt;
    ki_s      = (mode_q == ST_TRK) ? KI_TRK_S : KI_ACQ_S;
    acc_sum   = dir_up ? ($signed({2'b00, acc_q}) + ki_s) : ($signed({2'b00, acc_q}) - ki_s);
    acc_d     = evt_valid ? sat_acc(acc_sum) : acc_q;
    p_s       = '0;
    if (evt_valid) begin
      p_s = (mode_q == ST_TRK) ? KP_TRK_S : KP_ACQ_S;
      if (!dir_up) p_s = -p_s;
    end
    code_sum = $signed({2'b00, acc_d[ACC_W-1:FRAC_W]}) + p_s;
    code_d   = clamp_code(code_sum);
    sat_d    = (acc_d == '0) || (acc_d == ACC_MAX);
  end

  // Gain-schedule FSM with reversal/run counters.
  always_comb begin
    mode_d     = mode_q;
    last_up_d  = last_up_q;
    has_last_d = has_last_q;
    rev_cnt_d  = rev_cnt_q;
    run_cnt_d  = run_cnt_q;
    repeat_evt = evt_valid && has_last_q && (dir_up == last_up_q);
    reversal   = evt_valid && has_last_q && (dir_up != last_up_q);
    if (evt_valid) begin
      has_last_d = 1'b1;
      last_up_d  = dir_up;
      if (reversal) begin
        rev_cnt_d = (rev_cnt_q == REV_MAX) ? rev_cnt_q : rev_cnt_q + 1'b1;
        run_cnt_d = RL_W'(1);
      end else if (repeat_evt) begin
        rev_cnt_d = '0;
        run_cnt_d = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + 1'b1;
      end else begin
        run_cnt_d = RL_W'(1);
      end
      case (mode_q)
        ST_ACQ: if (rev_cnt_d == REV_MAX) begin
          mode_d    = ST_TRK;
          rev_cnt_d = '0;
        end
        ST_TRK: if (run_cnt_d == RUN_MAX) begin
          mode_d    = ST_ACQ;
          run_cnt_d = '0;
        end
        default: mode_d = ST_ACQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q      <= ACC_RST;
      code_q     <= CODE_RST;
      sat_q      <= 1'b0;
      mode_q     <= ST_ACQ;
      last_up_q  <= 1'b0;
      has_last_q <= 1'b0;
      rev_cnt_q  <= '0;
      run_cnt_q  <= '0;
    end else begin
      acc_q      <= acc_d;
      code_q     <= code_d;
      sat_q      <= sat_d;
      mode_q     <= mode_d;
      last_up_q  <= last_up_d;
      has_last_q <= has_last_d;
      rev_cnt_q  <= rev_cnt_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  assign dco_code = code_q;
  assign mode     = mode_q;
  assign code_sat = sat_q;

`ifdef LOOP_FILTER_LOCK_DET_EN
  localparam int LW_W = $clog2(LOCK_WIN + 1);
  localparam logic [LW_W-1:0] LOCK_MAX = LW_W'(LOCK_WIN);

  logic [LW_W-1:0] lock_cnt_q, lock_cnt_d;
  logic            locked_q, locked_d;

  // Counts quiet TRACK cycles; any repeat or leaving TRACK restarts it.
  always_comb begin
    lock_cnt_d = '0;
    if (mode_q == ST_TRK && mode_d == ST_TRK && !repeat_evt) begin
      lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
    end
    locked_d = (lock_cnt_d == LOCK_MAX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_loop_filter_pi.sv
// Self-checking bench for loop_filter_pi: directed scenarios plus randomized
// traffic against an arithmetic reference model of the PI filter.
module tb_loop_filter_pi;

  logic       clk = 1'b0;
  logic       reset;
  logic       UP_in;
  logic       DN_in;
  logic [9:0] dco_code;
  logic       mode;
  logic       code_sat;
  logic       locked;

  int errors = 0;
  int checks = 0;

`ifdef LOOP_FILTER_LOCK_DET_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  loop_filter_pi dut (
    .clk(clk), .reset(reset), .UP_in(UP_in), .DN_in(DN_in),
    .dco_code(dco_code), .mode(mode), .code_sat(code_sat), .locked(locked)
  );

  always #5 clk = ~clk;

  // Reference model state (plain integers).
  int m_acc, m_code, m_mode, m_sat, m_locked, m_lock, m_rev, m_run, m_last;
  bit m_up_prev, m_dn_prev;

  function automatic void model_step(input bit up, input bit dn, input bit rst_n);
    bit ue, de, rep;
    int dir, p, prev_mode;
    if (!rst_n) begin
      m_acc = 512 * 16; m_code = 512; m_mode = 0; m_sat = 0; m_locked = 0;
      m_lock = 0; m_rev = 0; m_run = 0; m_last = 0;
    end else begin
      ue = up && !m_up_prev;
      de = dn && !m_dn_prev;
      dir = 0; p = 0; rep = 0; prev_mode = m_mode;
      if (ue && !de) dir = 1;
      else if (de && !ue) dir = -1;
      if (dir != 0) begin
        m_acc = m_acc + dir * (m_mode ? 4 : 16);
        if (m_acc < 0) m_acc = 0;
        if (m_acc > 16383) m_acc = 16383;
        p = dir * (m_mode ? 2 : 8);
        if (m_last == 0) m_run = 1;
        else if (dir != m_last) begin m_rev++; m_run = 1; end
        else begin rep = 1; m_rev = 0; m_run++; end
        m_last = dir;
        if (m_mode == 0 && m_rev >= 4) begin m_mode = 1; m_rev = 0; end
        else if (m_mode == 1 && m_run >= 3) begin m_mode = 0; m_run = 0; end
      end
      m_code = m_acc / 16 + p;
      if (m_code < 0) m_code = 0;
      if (m_code > 1023) m_code = 1023;
      m_sat = (m_acc == 0 || m_acc == 16383) ? 1 : 0;
      if (LOCK_EN && prev_mode == 1 && m_mode == 1 && !rep)
        m_lock = (m_lock < 64) ? m_lock + 1 : 64;
      else
        m_lock = 0;
      m_locked = (m_lock == 64) ? 1 : 0;
    end
    m_up_prev = up;
    m_dn_prev = dn;
  endfunction

  task automatic cyc(input bit up, input bit dn, input bit rst_n);
    @(negedge clk);
    UP_in = up; DN_in = dn; reset = rst_n;
    @(posedge clk);
    model_step(up, dn, rst_n);
    #1;
  endtask

  task automatic pulse(input bit up, input bit dn);
    cyc(up, dn, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic apply_reset();
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if (dco_code !== 10'd512) begin errors++; $display("FAIL reset_code: got %0d expected 512", dco_code); end
    checks++; if (mode !== 1'b0) begin errors++; $display("FAIL reset_mode: got %0b expected 0", mode); end
    checks++; if (code_sat !== 1'b0) begin errors++; $display("FAIL reset_sat: got %0b expected 0", code_sat); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1);
    checks++; if (dco_code !== 10'd512) begin errors++; $display("FAIL release_held_up: got %0d expected 512", dco_code); end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (dco_code !== m_code[9:0]) begin errors++; $display("FAIL release_model: got %0d expected %0d", dco_code, m_code); end
  endtask

  task automatic test_pulse();
    apply_reset();
    cyc(1'b1, 1'b0, 1'b1);
    checks++; if (dco_code !== 10'd521) begin errors++; $display("FAIL up_kick: got %0d expected 521", dco_code); end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (dco_code !== 10'd513) begin errors++; $display("FAIL up_settle: got %0d expected 513", dco_code); end
    cyc(1'b0, 1'b1, 1'b1);
    checks++; if (dco_code !== 10'd504) begin errors++; $display("FAIL dn_kick: got %0d expected 504", dco_code); end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (dco_code !== 10'd512) begin errors++; $display("FAIL dn_settle: got %0d expected 512", dco_code); end
  endtask

  task automatic test_hold_and_cancel();
    apply_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (dco_code !== 10'd513) begin errors++; $display("FAIL held_up_once: got %0d expected 513", dco_code); end
    cyc(1'b1, 1'b1, 1'b1);
    checks++; if (dco_code !== 10'd513) begin errors++; $display("FAIL cancel_code: got %0d expected 513", dco_code); end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (dco_code !== 10'd513) begin errors++; $display("FAIL cancel_settle: got %0d expected 513", dco_code); end
    checks++; if (mode !== 1'b0) begin errors++; $display("FAIL cancel_mode: got %0b expected 0", mode); end
  endtask

  task automatic test_track();
    apply_reset();
    pulse(1'b1, 1'b0); pulse(1'b0, 1'b1); pulse(1'b1, 1'b0); pulse(1'b0, 1'b1);
    checks++; if (mode !== 1'b0) begin errors++; $display("FAIL four_events_mode: got %0b expected 0", mode); end
    cyc(1'b1, 1'b0, 1'b1);
    checks++; if (mode !== 1'b1) begin errors++; $display("FAIL enter_track: got %0b expected 1", mode); end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (dco_code !== 10'd513) begin errors++; $display("FAIL track_base: got %0d expected 513", dco_code); end
    cyc(1'b1, 1'b0, 1'b1);
    checks++; if (dco_code !== 10'd515) begin errors++; $display("FAIL track_kick: got %0d expected 515", dco_code); end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (dco_code !== 10'd513) begin errors++; $display("FAIL track_integral: got %0d expected 513", dco_code); end
    pulse(1'b0, 1'b1); pulse(1'b0, 1'b1);
    checks++; if (mode !== 1'b1) begin errors++; $display("FAIL two_dn_mode: got %0b expected 1", mode); end
    pulse(1'b0, 1'b1);
    checks++; if (mode !== 1'b0) begin errors++; $display("FAIL exit_track: got %0b expected 0", mode); end
    checks++; if (dco_code !== m_code[9:0]) begin errors++; $display("FAIL exit_code: got %0d expected %0d", dco_code, m_code); end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 512; i++) pulse(1'b0, 1'b1);
    checks++; if (dco_code !== 10'd0) begin errors++; $display("FAIL sat_low_code: got %0d expected 0", dco_code); end
    checks++; if (code_sat !== 1'b1) begin errors++; $display("FAIL sat_low_flag: got %0b expected 1", code_sat); end
    cyc(1'b0, 1'b1, 1'b1);
    checks++; if (dco_code !== 10'd0) begin errors++; $display("FAIL sat_kick_clamp: got %0d expected 0", dco_code); end
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1);
    checks++; if (dco_code !== 10'd9) begin errors++; $display("FAIL sat_up_kick: got %0d expected 9", dco_code); end
    checks++; if (code_sat !== 1'b0) begin errors++; $display("FAIL sat_release: got %0b expected 0", code_sat); end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (dco_code !== 10'd1) begin errors++; $display("FAIL sat_up_settle: got %0d expected 1", dco_code); end
  endtask

  task automatic test_lock();
    apply_reset();
    pulse(1'b1, 1'b0); pulse(1'b0, 1'b1); pulse(1'b1, 1'b0); pulse(1'b0, 1'b1); pulse(1'b1, 1'b0);
    for (int i = 0; i < 62; i++) cyc(1'b0, 1'b0, 1'b1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %0b expected 0", locked); end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (locked !== LOCK_EN) begin errors++; $display("FAIL lock_at_win: got %0b expected %0b", locked, LOCK_EN); end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (locked !== m_locked[0]) begin errors++; $display("FAIL lock_hold: got %0b expected %0b", locked, m_locked[0]); end
    cyc(1'b1, 1'b0, 1'b1);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_clear: got %0b expected 0", locked); end
    checks++; if (mode !== 1'b1) begin errors++; $display("FAIL lock_mode: got %0b expected 1", mode); end
  endtask

  task automatic test_random();
    bit up, dn, rn;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      rn = ($urandom_range(0, 299) != 0);
      up = ($urandom_range(0, 3) == 0);
      dn = ($urandom_range(0, 3) == 0);
      cyc(up, dn, rn);
      checks++;
      if ({dco_code, mode, code_sat, locked} !== {m_code[9:0], m_mode[0], m_sat[0], m_locked[0]}) begin
        errors++;
        $display("FAIL random_cycle %0d: got code=%0d mode=%0b sat=%0b locked=%0b expected code=%0d mode=%0b sat=%0b locked=%0b",
                 i, dco_code, mode, code_sat, locked, m_code, m_mode[0], m_sat[0], m_locked[0]);
      end
    end
  endtask

  initial begin
    reset = 1'b0; UP_in = 1'b0; DN_in = 1'b0;
    m_up_prev = 1'b0; m_dn_prev = 1'b0;
    model_step(1'b0, 1'b0, 1'b0);
    test_reset();
    test_pulse();
    test_hold_and_cancel();
    test_track();
    test_saturation();
    test_lock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
